// File: rtl/nios_setup_v2_key_pkg.sv
// nios_setup_v2_key_pkg
// Shared definitions for the key poller slice: poller FSM state encoding,
// the key PIO register map and the electrical sense of the push-button.
package nios_setup_v2_key_pkg;

  // Poll sequencer states: wait for the poll timer, issue the read strobe,
  // then capture the registered read data one cycle later.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2
  } key_state_e;

  // Data register of the key PIO responder.
  localparam logic [1:0] KEY_DATA_ADDR = 2'd0;

  // The responder returns read data on the cycle after the strobe, which is
  // why the LATCH state is exactly one cycle behind READ.
  localparam int KEY_READ_LATENCY = 1;

  // Keys are wired active-low: a pressed button reads back as 0.
  localparam logic KEY_PRESSED = 1'b0;

  // True when one more disagreeing poll reaches the debounce threshold.
  function automatic logic debounce_done(input logic [3:0] cnt,
                                         input logic [3:0] limit);
    return (cnt + 4'd1) == limit;
  endfunction

endpackage

// File: rtl/nios_setup_v2_key_poller_if.sv
// nios_setup_v2_key_poller_if
// Avalon-MM read-only link between the key poller (master) and the key PIO
// s1 port (slave).
//   address  : word address, master -> slave
//   read     : read strobe, master -> slave
//   readdata : registered read data, slave -> master (latency 1, no waitrequest)
interface nios_setup_v2_key_poller_if;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output readdata
  );
endinterface

// File: rtl/nios_setup_v2_key_poller_debounce.sv
// nios_setup_v2_key_debounce
// Debounce state for one active-low key. Each valid sample either confirms
// the current level (clearing the disagreement count) or counts towards a
// change; DEBOUNCE_CNT consecutive disagreeing samples flip the level and
// emit a one-cycle press or release pulse.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   sample        : raw key bit captured from the PIO (1 = released)
//   sample_valid  : high for the single cycle in which sample is meaningful
//   key_level     : debounced level, 1 = released, 0 = pressed
//   key_press     : one-cycle pulse on a 1->0 level change
//   key_release   : one-cycle pulse on a 0->1 level change
module nios_setup_v2_key_debounce
  import nios_setup_v2_key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic sample_valid,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CNT);

  // Disagreement count; wraps back to 0 when the threshold is reached, so it
  // never exceeds DEBOUNCE_CNT-1.
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 4'd0;
      key_level   <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      // Pulses default low so they are only ever one cycle wide.
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (sample_valid) begin
        if (sample == key_level) begin
          cnt <= 4'd0;
        end else if (debounce_done(cnt, DB_LIMIT)) begin
          key_level <= sample;
          cnt       <= 4'd0;
          // Exactly one direction applies since sample != key_level.
          if (sample == KEY_PRESSED) begin
            key_press <= 1'b1;
          end else begin
            key_release <= 1'b1;
          end
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/nios_setup_v2_key_poller.sv
// nios_setup_v2_key_poller
// Avalon-MM initiator that polls the single-bit key PIO every POLL_DIV
// cycles and turns the raw active-low key into a debounced level plus
// press/release pulses, without involving the Nios II processor.
// Parameters:
//   POLL_DIV     : cycles between read strobes (>= 3)
//   DEBOUNCE_CNT : consecutive disagreeing polls needed to change level (1..15)
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   enable       : polling enable; low parks the poller after any read in flight
//   avm          : Avalon master (address/read out, readdata in)
//   key_level    : debounced level, 1 = released, 0 = pressed
//   key_press    : one-cycle pulse on press
//   key_release  : one-cycle pulse on release
//   irq, irq_ack : sticky press interrupt and its acknowledge, only when the
//                  build defines KEY_POLLER_IRQ_EN
module nios_setup_v2_key_poller
  import nios_setup_v2_key_pkg::*;
#(
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  nios_setup_v2_key_poller_if.master        avm,
  output logic                              key_level,
  output logic                              key_press,
  output logic                              key_release
`ifdef KEY_POLLER_IRQ_EN
  ,
  output logic                              irq,
  input  logic                              irq_ack
`endif
);

  localparam int TIMER_W = $clog2(POLL_DIV);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);

  key_state_e         state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               sample_valid;

  // Only bit 0 carries the key; the rest of the PIO word is don't-care.
  logic unused_readdata;
  assign unused_readdata = ^avm.readdata[31:1];

  // ---- state / timer registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // ---- next-state and Avalon outputs ----
  // The timer free-runs through READ and LATCH so the strobe-to-strobe
  // period is exactly POLL_DIV; it only wraps in IDLE because POLL_DIV >= 3
  // guarantees READ/LATCH never coincide with the last count.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    sample_valid = 1'b0;
    avm.read     = 1'b0;
    avm.address  = KEY_DATA_ADDR;

    if (!enable) begin
      timer_next = '0;
    end else if (state == IDLE && timer == TIMER_LAST) begin
      timer_next = '0;
    end else begin
      timer_next = timer + TIMER_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (enable && timer == TIMER_LAST) begin
          state_next = READ;
        end
      end
      READ: begin
        // A read in flight always completes, even if enable drops now.
        avm.read   = 1'b1;
        state_next = LATCH;
      end
      LATCH: begin
        sample_valid = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---- debounce ----
  nios_setup_v2_key_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sample       (avm.readdata[0]),
    .sample_valid (sample_valid),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release)
  );

`ifdef KEY_POLLER_IRQ_EN
  // ---- press interrupt ----
  // A press arriving together with an acknowledge keeps the interrupt set.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (key_press) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_nios_setup_v2_key_poller.sv
// tb_nios_setup_v2_key_poller
// Directed bench for the key poller with POLL_DIV=8, DEBOUNCE_CNT=3. A
// responder model returns the key bit one cycle after each clock; every
// poll pushes the expected debounce outcome into a scoreboard that is
// popped when the update becomes visible two edges after the read strobe.
// Build with +define+KEY_POLLER_IRQ_EN to exercise the interrupt.
module tb_nios_setup_v2_key_poller;

  localparam int POLL_DIV = 8;
  localparam int DB_CNT   = 3;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic key_raw;
  logic key_level;
  logic key_press;
  logic key_release;
`ifdef KEY_POLLER_IRQ_EN
  logic irq;
  logic irq_ack;
`endif

  nios_setup_v2_key_poller_if bus ();

  always #5 clk = ~clk;

  // Key PIO responder: registered read data, junk in the upper bits.
  always @(posedge clk) begin
    bus.readdata <= {31'($urandom), key_raw};
  end

  nios_setup_v2_key_poller #(
    .POLL_DIV     (POLL_DIV),
    .DEBOUNCE_CNT (DB_CNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .avm         (bus),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
`ifdef KEY_POLLER_IRQ_EN
    ,
    .irq         (irq),
    .irq_ack     (irq_ack)
`endif
  );

  typedef struct packed {
    logic       level;
    logic       press;
    logic       rel;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_read = -1;
  int   t0;
  logic m_level = 1'b1;
  int   m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Poll-level model of the debounce rule.
  task automatic model_poll(input logic s, output exp_t e);
    e.press = 1'b0;
    e.rel   = 1'b0;
    if (s == m_level) begin
      m_cnt = 0;
    end else if (m_cnt + 1 == DB_CNT) begin
      m_level = s;
      m_cnt   = 0;
      e.press = (s == 1'b0);
      e.rel   = (s == 1'b1);
    end else begin
      m_cnt = m_cnt + 1;
    end
    e.level = m_level;
    e.cnt   = 4'(m_cnt);
  endtask

  // Advance until the read strobe, bounded; no pulses may appear meanwhile.
  task automatic wait_read(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
      if (bus.read !== 1'b1) begin
        check({tag, "_idle_press"}, 32'(key_press), 32'd0);
        check({tag, "_idle_release"}, 32'(key_release), 32'd0);
      end
    end while (bus.read !== 1'b1 && n < 2 * POLL_DIV);
    check({tag, "_read_seen"}, 32'(bus.read), 32'd1);
    check({tag, "_address"}, 32'(bus.address), 32'd0);
  endtask

  task automatic start_poll(input logic s, input bit chk_period, input string tag);
    exp_t e;
    key_raw = s;
    wait_read(tag);
    if (chk_period) check({tag, "_period"}, 32'(cyc - last_read), 32'(POLL_DIV));
    last_read = cyc;
    model_poll(s, e);
    sb.push_back(e);
  endtask

  task automatic finish_poll(input string tag);
    exp_t e;
    tick();  // LATCH cycle
    check({tag, "_latch_read"}, 32'(bus.read), 32'd0);
    check({tag, "_latch_press"}, 32'(key_press), 32'd0);
    check({tag, "_latch_release"}, 32'(key_release), 32'd0);
    tick();  // update visible
    e = sb.pop_front();
    check({tag, "_level"}, 32'(key_level), 32'(e.level));
    check({tag, "_press"}, 32'(key_press), 32'(e.press));
    check({tag, "_release"}, 32'(key_release), 32'(e.rel));
    check({tag, "_cnt"}, 32'(dut.u_debounce.cnt), 32'(e.cnt));
  endtask

  task automatic poll(input logic s, input string tag);
    start_poll(s, 1'b1, tag);
    finish_poll(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_read"}, 32'(bus.read), 32'd0);
    check({tag, "_address"}, 32'(bus.address), 32'd0);
    check({tag, "_level"}, 32'(key_level), 32'd1);
    check({tag, "_press"}, 32'(key_press), 32'd0);
    check({tag, "_release"}, 32'(key_release), 32'd0);
    check({tag, "_cnt"}, 32'(dut.u_debounce.cnt), 32'd0);
`ifdef KEY_POLLER_IRQ_EN
    check({tag, "_irq"}, 32'(irq), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    key_raw = 1'b1;
`ifdef KEY_POLLER_IRQ_EN
    irq_ack = 1'b0;
`endif
    tick();
    tick();
    check_reset_state("reset");

    // First read POLL_DIV-1 edges after the first edge without reset.
    reset = 1'b0;
    tick();
    t0 = cyc;
    start_poll(1'b1, 1'b0, "first");
    check("first_latency", 32'(cyc - t0), 32'(POLL_DIV - 1));
    finish_poll("first");

    // Released key: steady polling, no activity.
    for (int i = 0; i < 3; i++) poll(1'b1, "steady");

    // Press: pulse on the third poll, two edges after its strobe.
    for (int i = 0; i < 3; i++) poll(1'b0, "press");
    // Release after press.
    for (int i = 0; i < 3; i++) poll(1'b1, "release");

    // Glitch: two low samples then high must clear the count.
    poll(1'b0, "glitch");
    poll(1'b0, "glitch");
    poll(1'b1, "glitch");
    // A fresh press still needs three polls after the glitch.
    for (int i = 0; i < 3; i++) poll(1'b0, "repress");

    // Drop enable during READ: the sample still lands, then polling stops.
    start_poll(1'b1, 1'b1, "endrop");
    enable = 1'b0;
    finish_poll("endrop");
    for (int i = 0; i < 3 * POLL_DIV; i++) begin
      tick();
      check("disabled_read", 32'(bus.read), 32'd0);
    end
    enable = 1'b1;
    tick();
    t0 = cyc;
    start_poll(1'b1, 1'b0, "reenable");
    check("reenable_latency", 32'(cyc - t0), 32'(POLL_DIV - 1));
    finish_poll("reenable");
    poll(1'b1, "reenable");  // third high sample -> release

    // Reset during LATCH with a press about to be recognised.
    poll(1'b0, "rstlatch");
    poll(1'b0, "rstlatch");
    start_poll(1'b0, 1'b1, "rstlatch");
    void'(sb.pop_front());
    tick();  // LATCH
    reset = 1'b1;
    tick();
    check_reset_state("rst_in_latch");
    m_level = 1'b1;
    m_cnt   = 0;
    reset   = 1'b0;

`ifdef KEY_POLLER_IRQ_EN
    // Press coinciding with acknowledge leaves irq set; a later ack clears it.
    tick();
    t0 = cyc;
    start_poll(1'b0, 1'b0, "irq");
    finish_poll("irq");
    poll(1'b0, "irq");
    poll(1'b0, "irq");
    check("irq_before_set", 32'(irq), 32'd0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("irq_set_wins", 32'(irq), 32'd1);
    tick();
    check("irq_held", 32'(irq), 32'd1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("irq_cleared", 32'(irq), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
